// File: rtl/io_bank_pad_sequencer.sv
// Pad-bank enable sequencer: pulls/receivers first, settle wait, then output
// drivers enabled group by group. POC forces the bank safe; the stored config
// replays automatically once POC clears.
module io_bank_pad_sequencer #(
  parameter int NUM_PADS       = 8,
  parameter int GROUP_SIZE     = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  POC,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [NUM_PADS-1:0]   cfg_out_en,
  input  logic [NUM_PADS-1:0]   cfg_pull_en,
  input  logic [NUM_PADS-1:0]   cfg_ie,
  input  logic [NUM_PADS/2-1:0] cfg_lvds_en,
  output logic [NUM_PADS-1:0]   OEN,
  output logic [NUM_PADS-1:0]   REN,
  output logic [NUM_PADS-1:0]   IE,
  output logic [NUM_PADS/2-1:0] lvdsen,
  output logic                  bank_ready,
  output logic                  busy
);
  localparam int NP   = NUM_PADS / 2;
  localparam int NG   = NUM_PADS / GROUP_SIZE;
  localparam int CMAX = (SETTLE_CYCLES > STAGGER_CYCLES) ? SETTLE_CYCLES : STAGGER_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LD = CW'(STAGGER_CYCLES - 1);
  localparam logic [GW-1:0] LAST_GRP   = GW'(NG - 1);

  typedef enum logic [2:0] {S_SAFE, S_IDLE, S_PULL, S_DRIVE, S_READY, S_DISABLE} state_t;

  state_t              r_state;
  logic                r_poc_meta, r_poc_s, r_cfg_loaded;
  logic [CW-1:0]       r_cnt;
  logic [GW-1:0]       r_grp;
  logic [NUM_PADS-1:0] r_out_en, r_pull_en, r_ie;
  logic [NP-1:0]       r_lvds_en;

  logic [NUM_PADS-1:0] w_lvds_mask, w_grp_mask;
  logic [NUM_PADS-1:0] w_out_eff, w_pull_eff, w_ie_eff;
  logic                w_accept;

  // LVDS pairs are receive-only: both pads lose driver, pull and single-ended input.
  // Drivers of group g are on once the group index has reached g.
  for (genvar p = 0; p < NP; p++) begin : g_pair
    assign w_lvds_mask[2*p +: 2] = {2{r_lvds_en[p]}};
  end
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    assign w_grp_mask[i] = (GW'(i / GROUP_SIZE) <= r_grp);
  end

  assign w_out_eff  = r_out_en  & ~w_lvds_mask;
  assign w_pull_eff = r_pull_en & ~w_lvds_mask;
  assign w_ie_eff   = r_ie      & ~w_lvds_mask;
  assign w_accept   = cfg_valid & cfg_ready & ~r_poc_s &
                      ((r_state == S_IDLE) | (r_state == S_READY));

  // POC resynchroniser; resets to "supply ready" so release goes straight to IDLE.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_poc_meta <= 1'b0;
      r_poc_s    <= 1'b0;
    end else begin
      r_poc_meta <= POC;
      r_poc_s    <= r_poc_meta;
    end
  end

  // Config store; survives POC so the bank can be replayed without software.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_out_en     <= '0;
      r_pull_en    <= '0;
      r_ie         <= '0;
      r_lvds_en    <= '0;
      r_cfg_loaded <= 1'b0;
    end else if (w_accept) begin
      r_out_en     <= cfg_out_en;
      r_pull_en    <= cfg_pull_en;
      r_ie         <= cfg_ie;
      r_lvds_en    <= cfg_lvds_en;
      r_cfg_loaded <= 1'b1;
    end
  end

  // Sequencing FSM with shared settle/stagger down-counter and group index.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_SAFE;
      r_cnt   <= '0;
      r_grp   <= '0;
    end else if (r_poc_s) begin
      r_state <= S_SAFE;
      r_cnt   <= '0;
      r_grp   <= '0;
    end else begin
      case (r_state)
        S_SAFE: begin
          r_state <= r_cfg_loaded ? S_PULL : S_IDLE;
          r_cnt   <= r_cfg_loaded ? SETTLE_LD : '0;
          r_grp   <= '0;
        end
        S_IDLE: if (w_accept) begin
          r_state <= S_PULL;
          r_cnt   <= SETTLE_LD;
          r_grp   <= '0;
        end
        S_PULL: begin
          if (r_cnt == '0) begin
            r_state <= S_DRIVE;
            r_cnt   <= STAGGER_LD;
            r_grp   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DRIVE: begin
          if (r_cnt == '0) begin
            r_cnt <= STAGGER_LD;
            if (r_grp == LAST_GRP) begin
              r_state <= S_READY;
              r_grp   <= '0;
            end else begin
              r_grp <= r_grp + GW'(1);
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_READY: if (w_accept) begin
          r_state <= S_DISABLE;
          r_cnt   <= '0;
          r_grp   <= '0;
        end
        S_DISABLE: begin
          r_state <= S_PULL;
          r_cnt   <= SETTLE_LD;
          r_grp   <= '0;
        end
        default: begin
          r_state <= S_SAFE;
          r_cnt   <= '0;
          r_grp   <= '0;
        end
      endcase
    end
  end

  // Registered pad controls decoded from the current state; a synced POC overrides to safe.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OEN        <= '1;
      REN        <= '0;
      IE         <= '0;
      lvdsen     <= '0;
      bank_ready <= 1'b0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b1;
    end else begin
      cfg_ready  <= ((r_state == S_IDLE) || (r_state == S_READY)) && !w_accept && !r_poc_s;
      bank_ready <= (r_state == S_READY) && !r_poc_s;
      busy       <= r_poc_s || (r_state == S_PULL) || (r_state == S_DRIVE) ||
                    (r_state == S_DISABLE) || (r_state == S_SAFE);
      if (r_poc_s) begin
        OEN    <= '1;
        REN    <= '0;
        IE     <= '0;
        lvdsen <= '0;
      end else begin
        case (r_state)
          S_PULL: begin
            OEN    <= '1;
            REN    <= ~w_pull_eff;
            IE     <= w_ie_eff;
            lvdsen <= r_lvds_en;
          end
          S_DRIVE: begin
            OEN    <= ~(w_out_eff & w_grp_mask);
            REN    <= ~w_pull_eff;
            IE     <= w_ie_eff;
            lvdsen <= r_lvds_en;
          end
          S_READY: begin
            OEN    <= ~w_out_eff;
            REN    <= ~w_pull_eff;
            IE     <= w_ie_eff;
            lvdsen <= r_lvds_en;
          end
          // Drivers off for one cycle; pulls/inputs keep the previous config.
          S_DISABLE: OEN <= '1;
          default: begin
            OEN    <= '1;
            REN    <= '0;
            IE     <= '0;
            lvdsen <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_io_bank_pad_sequencer.sv
// Directed bench for io_bank_pad_sequencer: reset, bring-up timing, reconfigure,
// handshake blocking, LVDS override, reset mid-sequence and POC abort/replay.
module tb_io_bank_pad_sequencer;
  logic       CLK = 1'b0;
  logic       RSTN, POC, cfg_valid, cfg_ready, bank_ready, busy;
  logic [7:0] cfg_out_en, cfg_pull_en, cfg_ie, OEN, REN, IE;
  logic [3:0] cfg_lvds_en, lvdsen;
  int checks = 0;
  int errors = 0;

  io_bank_pad_sequencer #(.NUM_PADS(8), .GROUP_SIZE(2), .SETTLE_CYCLES(16), .STAGGER_CYCLES(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .POC(POC), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_out_en(cfg_out_en), .cfg_pull_en(cfg_pull_en), .cfg_ie(cfg_ie), .cfg_lvds_en(cfg_lvds_en),
    .OEN(OEN), .REN(REN), .IE(IE), .lvdsen(lvdsen), .bank_ready(bank_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // One rising edge, then park on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Offer a config at the current falling edge; the next rising edge is edge 0.
  task automatic accept(input logic [7:0] o, input logic [7:0] p, input logic [7:0] i,
                        input logic [3:0] l, input bit hold);
    cfg_out_en = o; cfg_pull_en = p; cfg_ie = i; cfg_lvds_en = l; cfg_valid = 1'b1;
    tick();
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b1; POC = 1'b0; cfg_valid = 1'b0;
    cfg_out_en = '0; cfg_pull_en = '0; cfg_ie = '0; cfg_lvds_en = '0;
    #1 RSTN = 1'b0;
    #2;
    checks++; if (OEN !== 8'hFF) begin errors++; $display("FAIL reset_oen got %h exp ff", OEN); end
    checks++; if (REN !== 8'h00) begin errors++; $display("FAIL reset_ren got %h exp 00", REN); end
    checks++; if (IE !== 8'h00) begin errors++; $display("FAIL reset_ie got %h exp 00", IE); end
    checks++; if (lvdsen !== 4'h0) begin errors++; $display("FAIL reset_lvdsen got %h exp 0", lvdsen); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL reset_bank_ready got %b exp 0", bank_ready); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready got %b exp 0", cfg_ready); end
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready_e1 got %b exp 0", cfg_ready); end
    tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready_e2 got %b exp 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_idle got %b exp 0", busy); end
  endtask

  task automatic test_bringup();
    logic [7:0] exp_oen;
    accept(8'hFF, 8'h0F, 8'hFF, 4'h0, 1'b0);
    checks++; if (REN !== 8'h00) begin errors++; $display("FAIL bringup_ren_e0 got %h exp 00", REN); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL bringup_cfg_ready_e0 got %b exp 0", cfg_ready); end
    for (int n = 1; n <= 34; n++) begin
      tick();
      exp_oen = (n < 17) ? 8'hFF : (n < 21) ? 8'hFC : (n < 25) ? 8'hF0 : (n < 29) ? 8'hC0 : 8'h00;
      checks++; if (OEN !== exp_oen) begin errors++; $display("FAIL bringup_oen n=%0d got %h exp %h", n, OEN, exp_oen); end
      checks++; if (bank_ready !== 1'(n >= 33)) begin errors++; $display("FAIL bringup_bank_ready n=%0d got %b exp %b", n, bank_ready, n >= 33); end
      if (n == 1) begin
        checks++; if (REN !== 8'hF0) begin errors++; $display("FAIL bringup_ren got %h exp f0", REN); end
        checks++; if (IE !== 8'hFF) begin errors++; $display("FAIL bringup_ie got %h exp ff", IE); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bringup_busy got %b exp 1", busy); end
      end
      if (n == 33) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bringup_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bringup_busy_ready got %b exp 0", busy); end
      end
    end
  endtask

  task automatic test_reconfig();
    logic [7:0] exp_oen;
    accept(8'h0F, 8'h3C, 8'hFF, 4'h0, 1'b0);
    checks++; if (OEN !== 8'h00) begin errors++; $display("FAIL reconfig_oen_e0 got %h exp 00", OEN); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reconfig_cfg_ready_e0 got %b exp 0", cfg_ready); end
    for (int n = 1; n <= 35; n++) begin
      tick();
      exp_oen = (n < 18) ? 8'hFF : (n < 22) ? 8'hFC : 8'hF0;
      checks++; if (OEN !== exp_oen) begin errors++; $display("FAIL reconfig_oen n=%0d got %h exp %h", n, OEN, exp_oen); end
      checks++; if (bank_ready !== 1'(n >= 34)) begin errors++; $display("FAIL reconfig_bank_ready n=%0d got %b exp %b", n, bank_ready, n >= 34); end
      if (n == 1) begin
        checks++; if (REN !== 8'hF0) begin errors++; $display("FAIL reconfig_disable_ren got %h exp f0", REN); end
      end
      if (n == 2) begin
        checks++; if (REN !== 8'hC3) begin errors++; $display("FAIL reconfig_pull_ren got %h exp c3", REN); end
      end
    end
  endtask

  task automatic test_handshake();
    accept(8'hFF, 8'h00, 8'h00, 4'h0, 1'b1);
    cfg_out_en = 8'h55; cfg_pull_en = 8'h55; cfg_ie = 8'h55; cfg_lvds_en = 4'hF;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL handshake_cfg_ready n=0 got %b exp 0", cfg_ready); end
    for (int n = 1; n <= 33; n++) begin
      tick();
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL handshake_cfg_ready n=%0d got %b exp 0", n, cfg_ready); end
    end
    cfg_valid = 1'b0;
    tick();
    checks++; if (OEN !== 8'h00) begin errors++; $display("FAIL handshake_oen got %h exp 00", OEN); end
    checks++; if (REN !== 8'hFF) begin errors++; $display("FAIL handshake_ren got %h exp ff", REN); end
    checks++; if (IE !== 8'h00) begin errors++; $display("FAIL handshake_ie got %h exp 00", IE); end
    checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL handshake_bank_ready got %b exp 1", bank_ready); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL handshake_cfg_ready_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_lvds();
    accept(8'hFF, 8'hFF, 8'hFF, 4'b0010, 1'b0);
    tick();
    checks++; if (REN !== 8'hFF) begin errors++; $display("FAIL lvds_disable_ren got %h exp ff", REN); end
    checks++; if (lvdsen !== 4'h0) begin errors++; $display("FAIL lvds_disable_lvdsen got %h exp 0", lvdsen); end
    tick();
    checks++; if (REN !== 8'h0C) begin errors++; $display("FAIL lvds_pull_ren got %h exp 0c", REN); end
    checks++; if (IE !== 8'hF3) begin errors++; $display("FAIL lvds_pull_ie got %h exp f3", IE); end
    checks++; if (lvdsen !== 4'b0010) begin errors++; $display("FAIL lvds_pull_lvdsen got %h exp 2", lvdsen); end
    checks++; if (OEN !== 8'hFF) begin errors++; $display("FAIL lvds_pull_oen got %h exp ff", OEN); end
    for (int n = 3; n <= 34; n++) tick();
    checks++; if (OEN !== 8'h0C) begin errors++; $display("FAIL lvds_final_oen got %h exp 0c", OEN); end
    checks++; if (REN !== 8'h0C) begin errors++; $display("FAIL lvds_final_ren got %h exp 0c", REN); end
    checks++; if (IE !== 8'hF3) begin errors++; $display("FAIL lvds_final_ie got %h exp f3", IE); end
    checks++; if (lvdsen !== 4'b0010) begin errors++; $display("FAIL lvds_final_lvdsen got %h exp 2", lvdsen); end
    checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL lvds_final_bank_ready got %b exp 1", bank_ready); end
  endtask

  task automatic test_reset_mid_drive();
    accept(8'hFF, 8'h0F, 8'hFF, 4'h0, 1'b0);
    for (int n = 1; n <= 20; n++) tick();
    checks++; if (OEN !== 8'hFC) begin errors++; $display("FAIL rstmid_pre_oen got %h exp fc", OEN); end
    #2 RSTN = 1'b0;
    #1;
    checks++; if (OEN !== 8'hFF) begin errors++; $display("FAIL rstmid_oen got %h exp ff", OEN); end
    checks++; if (REN !== 8'h00) begin errors++; $display("FAIL rstmid_ren got %h exp 00", REN); end
    checks++; if (IE !== 8'h00) begin errors++; $display("FAIL rstmid_ie got %h exp 00", IE); end
    checks++; if (lvdsen !== 4'h0) begin errors++; $display("FAIL rstmid_lvdsen got %h exp 0", lvdsen); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL rstmid_bank_ready got %b exp 0", bank_ready); end
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_cfg_ready_e1 got %b exp 0", cfg_ready); end
    tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cfg_ready_e2 got %b exp 1", cfg_ready); end
    checks++; if (REN !== 8'h00) begin errors++; $display("FAIL rstmid_idle_ren got %h exp 00", REN); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_poc();
    accept(8'hFF, 8'h0F, 8'hFF, 4'h0, 1'b0);
    for (int n = 1; n <= 21; n++) tick();
    checks++; if (OEN !== 8'hF0) begin errors++; $display("FAIL poc_pre_oen got %h exp f0", OEN); end
    POC = 1'b1;
    cfg_valid = 1'b1; cfg_out_en = 8'h00; cfg_pull_en = 8'h00; cfg_ie = 8'h00; cfg_lvds_en = 4'h0;
    for (int n = 22; n <= 25; n++) tick();
    checks++; if (OEN !== 8'hFF) begin errors++; $display("FAIL poc_safe_oen got %h exp ff", OEN); end
    checks++; if (REN !== 8'h00) begin errors++; $display("FAIL poc_safe_ren got %h exp 00", REN); end
    checks++; if (IE !== 8'h00) begin errors++; $display("FAIL poc_safe_ie got %h exp 00", IE); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL poc_safe_bank_ready got %b exp 0", bank_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL poc_safe_busy got %b exp 1", busy); end
    for (int n = 26; n <= 30; n++) begin
      tick();
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL poc_cfg_ready n=%0d got %b exp 0", n, cfg_ready); end
    end
    POC = 1'b0;
    cfg_valid = 1'b0;
    for (int n = 31; n <= 67; n++) begin
      tick();
      if (n == 33) begin
        checks++; if (REN !== 8'h00) begin errors++; $display("FAIL poc_replay_ren_early got %h exp 00", REN); end
      end
      if (n == 34) begin
        checks++; if (REN !== 8'hF0) begin errors++; $display("FAIL poc_replay_ren got %h exp f0", REN); end
      end
      if (n == 65) begin
        checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL poc_replay_ready_early got %b exp 0", bank_ready); end
      end
      if (n == 66) begin
        checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL poc_replay_ready got %b exp 1", bank_ready); end
        checks++; if (OEN !== 8'h00) begin errors++; $display("FAIL poc_replay_oen got %h exp 00", OEN); end
      end
      if (n == 67) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL poc_replay_cfg_ready got %b exp 1", cfg_ready); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_reconfig();
    test_handshake();
    test_lvds();
    test_reset_mid_drive();
    test_poc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "simulation time limit");
  end
endmodule
